// File: rtl/pc_next_unit_pkg.sv
// rtl/pc_next_unit_pkg.sv - shared constants for the PC / next-PC unit
// Contents: ALU zero comparison codes, branch funct3 codes, FSM state type.
package pc_next_unit_pkg;

    // ALU comparison codes carried on the 2-bit zero bus
    localparam logic [1:0] ZC_EQUAL   = 2'b00;
    localparam logic [1:0] ZC_GREATER = 2'b01;
    localparam logic [1:0] ZC_LESS    = 2'b10;
    localparam logic [1:0] ZC_OTHER   = 2'b11;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_next_unit_branch_cond.sv
// rtl/pc_next_unit_branch_cond.sv - combinational branch taken decision
// Ports:
//   i_is_branch : current instruction is a conditional branch
//   i_funct3    : branch funct3
//   i_zero      : ALU comparison code
//   o_taken     : branch is taken
module branch_cond
    import pc_next_unit_pkg::*;
(
    input  logic       i_is_branch,
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_zero,
    output logic       o_taken
);

    // The ALU compare for BLT/BLTU reports GREATER when rs1 < rs2, and for
    // BGE/BGEU reports EQUAL when rs1 >= rs2. OTHER never takes a branch.
    always_comb begin
        o_taken = 1'b0;
        if (i_is_branch && (i_zero != ZC_OTHER)) begin
            case (i_funct3)
                F3_BEQ, F3_BGE, F3_BGEU: o_taken = (i_zero == ZC_EQUAL);
                F3_BNE:                  o_taken = (i_zero != ZC_EQUAL);
                F3_BLT, F3_BLTU:         o_taken = (i_zero == ZC_GREATER);
                default:                 o_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter, next-PC select, boot/run/halt FSM
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_stall, i_halt_req : hold PC this cycle / stop fetching
//   i_is_branch/jal/jalr, i_br_funct3, i_zero, i_alu_result, i_imm : control-flow inputs
//   o_pc, o_pc4         : current PC and its link value
//   o_fetch_valid, o_branch_taken, o_misalign_err, o_halted, o_instret : status
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_halt_req,
    input  logic             i_is_branch,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic [2:0]       i_br_funct3,
    input  logic [1:0]       i_zero,
    input  logic [31:0]      i_alu_result,
    input  logic [31:0]      i_imm,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pc4,
    output logic             o_fetch_valid,
    output logic             o_branch_taken,
    output logic             o_misalign_err,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_instret
);

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [31:0]       r_pc;
    logic [CNT_W-1:0]  r_instret;
    logic              r_misalign;
    logic              w_br_taken;
    logic [31:0]       w_npc;
    logic              w_retire;
    logic              w_set_mis;

    branch_cond u_branch_cond (
        .i_is_branch (i_is_branch),
        .i_funct3    (i_br_funct3),
        .i_zero      (i_zero),
        .o_taken     (w_br_taken)
    );

    // JALR clears bit 0 of the target; JAL and taken branches are PC-relative.
    always_comb begin
        if (i_is_jalr)
            w_npc = i_alu_result & ~32'h1;
        else if (i_is_jal || w_br_taken)
            w_npc = r_pc + i_imm;
        else
            w_npc = r_pc + 32'd4;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_set_mis   = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (i_stall) begin
                    w_state_nxt = ST_RUN;
                end else if (w_npc[1:0] != 2'b00) begin
                    w_state_nxt = ST_HALT;
                    w_set_mis   = 1'b1;
                end else begin
                    w_retire    = 1'b1;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= RESET_VEC;
            r_instret  <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (w_retire) begin
                r_pc      <= w_npc;
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_set_mis)
                r_misalign <= 1'b1;
        end
    end

    assign o_pc           = r_pc;
    assign o_pc4          = r_pc + 32'd4;
    assign o_fetch_valid  = (r_state == ST_RUN);
    assign o_halted       = (r_state == ST_HALT);
    assign o_branch_taken = i_is_jal | i_is_jalr | w_br_taken;
    assign o_misalign_err = r_misalign;
    assign o_instret      = r_instret;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - scoreboard bench for pc_next_unit
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt_req, is_branch, is_jal, is_jalr;
    logic [2:0]  br_funct3;
    logic [1:0]  zero;
    logic [31:0] alu_result, imm;
    logic [31:0] pc, pc4, instret;
    logic        fetch_valid, branch_taken, misalign_err, halted;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic        halted;
        logic        mis;
        logic        fv;
    } exp_t;

    exp_t sb_q[$];

    // reference model state: 0 boot, 1 run, 2 halt
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_next_unit #(.RESET_VEC(32'h0000_0000), .CNT_W(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_stall        (stall),
        .i_halt_req     (halt_req),
        .i_is_branch    (is_branch),
        .i_is_jal       (is_jal),
        .i_is_jalr      (is_jalr),
        .i_br_funct3    (br_funct3),
        .i_zero         (zero),
        .i_alu_result   (alu_result),
        .i_imm          (imm),
        .o_pc           (pc),
        .o_pc4          (pc4),
        .o_fetch_valid  (fetch_valid),
        .o_branch_taken (branch_taken),
        .o_misalign_err (misalign_err),
        .o_halted       (halted),
        .o_instret      (instret)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic model_taken(input logic br, input logic [2:0] f3, input logic [1:0] z);
        if (!br || z == 2'b11) return 1'b0;
        case (f3)
            3'b000: return z == 2'b00;
            3'b001: return z != 2'b00;
            3'b100: return z == 2'b01;
            3'b101: return z == 2'b00;
            3'b110: return z == 2'b01;
            3'b111: return z == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_pc = 32'h0; m_instret = 32'h0; m_mis = 1'b0;
    endtask

    // Drive one cycle of controls, check the zero-latency outputs, push the
    // expected registered state, clock it and compare against the pop.
    task automatic step(input logic st, input logic hr, input logic br, input logic jal,
                        input logic jalr, input logic [2:0] f3, input logic [1:0] z,
                        input logic [31:0] alu, input logic [31:0] im);
        logic        tk;
        logic [31:0] npc;
        exp_t        e, got;
        stall = st; halt_req = hr; is_branch = br; is_jal = jal; is_jalr = jalr;
        br_funct3 = f3; zero = z; alu_result = alu; imm = im;
        #1;
        tk = model_taken(br, f3, z);
        check("branch_taken", {31'b0, branch_taken}, {31'b0, (jal | jalr | tk)});
        check("pc4", pc4, m_pc + 32'd4);
        if (jalr)           npc = {alu[31:1], 1'b0};
        else if (jal || tk) npc = m_pc + im;
        else                npc = m_pc + 32'd4;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (hr) m_state = 2;
            else if (st) ;
            else if (npc[1:0] != 2'b00) begin m_state = 2; m_mis = 1'b1; end
            else begin m_pc = npc; m_instret = m_instret + 32'd1; end
        end
        e.pc = m_pc; e.instret = m_instret; e.halted = (m_state == 2);
        e.mis = m_mis; e.fv = (m_state == 1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("pc", pc, got.pc);
        check("instret", instret, got.instret);
        check("halted", {31'b0, halted}, {31'b0, got.halted});
        check("misalign_err", {31'b0, misalign_err}, {31'b0, got.mis});
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, got.fv});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 3'b000, 2'b11, 32'h0, 32'h0);
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        step(0, 0, 0, 0, 1, 3'b000, 2'b11, tgt, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; halt_req = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
        br_funct3 = 3'b000; zero = 2'b11; alu_result = 32'h0; imm = 32'h0;
        model_reset();
        do_reset();

        // BOOT cycle, then sequential fetch
        check("boot_fv", {31'b0, fetch_valid}, 32'h0);
        for (int i = 0; i < 4; i++) idle();

        // BEQ taken / not taken
        jump_to(32'h100);
        step(0, 0, 1, 0, 0, 3'b000, 2'b00, 32'h0, 32'h40);
        check("beq_taken_pc", pc, 32'h140);
        jump_to(32'h100);
        step(0, 0, 1, 0, 0, 3'b000, 2'b01, 32'h0, 32'h40);
        check("beq_not_pc", pc, 32'h104);

        // BLT taken backward, BGE not taken
        jump_to(32'h200);
        step(0, 0, 1, 0, 0, 3'b100, 2'b01, 32'h0, 32'hFFFF_FFF8);
        check("blt_pc", pc, 32'h1F8);
        jump_to(32'h200);
        step(0, 0, 1, 0, 0, 3'b101, 2'b01, 32'h0, 32'hFFFF_FFF8);
        check("bge_pc", pc, 32'h204);

        // remaining funct3 / zero combinations
        step(0, 0, 1, 0, 0, 3'b001, 2'b10, 32'h0, 32'h10);  // BNE taken
        step(0, 0, 1, 0, 0, 3'b001, 2'b11, 32'h0, 32'h10);  // BNE, OTHER
        step(0, 0, 1, 0, 0, 3'b110, 2'b01, 32'h0, 32'h20);  // BLTU taken
        step(0, 0, 1, 0, 0, 3'b111, 2'b00, 32'h0, 32'h20);  // BGEU taken
        step(0, 0, 1, 0, 0, 3'b010, 2'b00, 32'h0, 32'h20);  // bad funct3
        step(0, 0, 0, 0, 0, 3'b000, 2'b00, 32'h0, 32'h20);  // not a branch
        step(0, 0, 0, 1, 0, 3'b000, 2'b11, 32'h0, 32'h800); // JAL
        step(0, 0, 1, 1, 1, 3'b000, 2'b00, 32'h3001, 32'h8); // JALR beats all

        // stall holds pc and instret
        jump_to(32'h20);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 3'b000, 2'b11, 32'h0, 32'h0);
        check("stall_pc", pc, 32'h20);
        jump_to(32'h1001);
        check("jalr_mask_pc", pc, 32'h1000);

        // wrap
        jump_to(32'hFFFF_FFFC);
        idle();
        check("wrap_pc", pc, 32'h0);

        // halt_req with stall, HALT frozen
        step(1, 1, 0, 0, 0, 3'b000, 2'b11, 32'h0, 32'h0);
        idle();
        jump_to(32'h400);

        // async reset mid-cycle from HALT
        do_reset();

        // halt_req in BOOT ignored; then misaligned JALR target
        step(0, 1, 0, 0, 0, 3'b000, 2'b11, 32'h0, 32'h0);
        idle();
        jump_to(32'h1003);
        check("mis_flag", {31'b0, misalign_err}, 32'h1);
        idle();
        do_reset();
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
